// File: rtl/apb_bus_arbiter_pkg.sv
// Shared types and constants for the APB bus arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } arb_state_e;

   // Read data returned to the requester when the slave never answers.
   localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_bus_arbiter_if.sv
// Bundle of requester-side and APB-master-side signals around the arbiter.
// The arbiter uses the slave modport; whoever drives the requests and models
// the APB master uses the master modport.
interface apb_bus_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);

   logic [NUM_REQ-1:0]        m_transfer;
   logic [NUM_REQ-1:0]        m_write;
   logic [NUM_REQ*ADDR_W-1:0] m_addr;
   logic [NUM_REQ*DATA_W-1:0] m_wdata;
   logic [NUM_REQ-1:0]        m_ready;
   logic [DATA_W-1:0]         m_rdata;
   logic                      m_error;

   logic                      s_transfer;
   logic                      s_write;
   logic [ADDR_W-1:0]         s_addr;
   logic [DATA_W-1:0]         s_wdata;
   logic                      s_ready;
   logic [DATA_W-1:0]         s_rdata;

   modport slave (
      input  m_transfer, m_write, m_addr, m_wdata, s_ready, s_rdata,
      output m_ready, m_rdata, m_error, s_transfer, s_write, s_addr, s_wdata
   );

   modport master (
      output m_transfer, m_write, m_addr, m_wdata, s_ready, s_rdata,
      input  m_ready, m_rdata, m_error, s_transfer, s_write, s_addr, s_wdata
   );

endinterface

// File: rtl/apb_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: returns the first requesting index found
// when searching upward from last_grant+1, wrapping around. The previous owner
// is therefore examined last and has the lowest priority.
module rr_priority_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [$clog2(NUM_REQ)-1:0] grant,
   output logic                       valid
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic [ID_W-1:0] idx;

   // Walk the requesters in rotated order and keep the first hit.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
         if (!valid && req[idx]) begin
            valid = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter sharing one APB master front-end among NUM_REQ
// requesters. One transaction at a time: the winner's request is latched,
// a single-cycle start pulse is sent to the APB master, and the completion
// (or a timeout abort) is routed back to the owning requester.
module apb_bus_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   apb_bus_arbiter_if.slave           bus,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e       state;
   arb_state_e       next_state;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  pick_grant;
   logic             pick_valid;
   logic             load;
   logic             done_ok;
   logic             done_err;
   logic [CNT_W-1:0] count;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req        (bus.m_transfer),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .valid      (pick_valid)
   );

   assign bus.s_transfer = (state == ISSUE);
   assign busy           = (state != IDLE);

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode plus one-cycle strobes for latch, completion and abort.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      done_ok    = 1'b0;
      done_err   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               load       = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            next_state = WAIT;
         end
         WAIT: begin
            if (bus.s_ready) begin
               done_ok    = 1'b1;
               next_state = IDLE;
            end else if ((TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1))) begin
               done_err   = 1'b1;
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Request latches, saturating wait counter and registered completion pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant_id     <= '0;
         last_grant   <= ID_W'(NUM_REQ - 1);
         count        <= '0;
         bus.s_write  <= 1'b0;
         bus.s_addr   <= '0;
         bus.s_wdata  <= '0;
         bus.m_ready  <= '0;
         bus.m_rdata  <= '0;
         bus.m_error  <= 1'b0;
      end else begin
         bus.m_ready <= '0;
         bus.m_rdata <= '0;
         bus.m_error <= 1'b0;

         if (load) begin
            grant_id    <= pick_grant;
            bus.s_write <= bus.m_write[pick_grant];
            bus.s_addr  <= bus.m_addr[pick_grant*ADDR_W +: ADDR_W];
            bus.s_wdata <= bus.m_wdata[pick_grant*DATA_W +: DATA_W];
         end

         if (state == ISSUE) begin
            count <= '0;
         end else if ((state == WAIT) && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
         end

         if (done_ok) begin
            bus.m_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
            bus.m_rdata <= bus.s_rdata;
            last_grant  <= grant_id;
         end else if (done_err) begin
            bus.m_ready <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
            bus.m_error <= 1'b1;
            bus.m_rdata <= DATA_W'(ARB_ERR_DATA);
            last_grant  <= grant_id;
         end
      end
   end

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter: stimulus pushes the expected APB
// start and the expected requester completion into queues; a monitor pops
// and compares whenever the arbiter presents s_transfer or m_ready.
module tb_apb_bus_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 8;

   typedef struct {
      int          id;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } xfer_t;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic [0:0]  grant_id;
   logic        busy;

   int          checks      = 0;
   int          failures    = 0;
   int          cyc         = 0;
   int          xfer_cyc    = 0;
   int          ready_cyc   = 0;
   int          slave_delay = 1;
   logic        slave_mute  = 1'b0;
   int          stray_req   = 0;

   xfer_t       xfer_q[$];
   resp_t       resp_q[$];
   logic [31:0] rdata_q[$];

   apb_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   apb_bus_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic report_timeout(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s actual=timeout required=event", name);
   endtask

   // Raise a request level and hold it until the requester's m_ready pulse.
   task automatic apply_stimulus(input int idx, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata);
      bus.m_write[idx]            = wr;
      bus.m_addr[idx*32 +: 32]    = addr;
      bus.m_wdata[idx*32 +: 32]   = wdata;
      bus.m_transfer[idx]         = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk);
         #1;
         if (bus.m_ready[idx]) begin
            bus.m_transfer[idx] = 1'b0;
            return;
         end
      end
      bus.m_transfer[idx] = 1'b0;
      report_timeout("ready_wait");
   endtask

   task automatic wait_xfer(input string name);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.s_transfer) return;
      end
      report_timeout(name);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_m_ready"},    64'(bus.m_ready),    64'd0);
      check_output({tag, "_m_rdata"},    64'(bus.m_rdata),    64'd0);
      check_output({tag, "_m_error"},    64'(bus.m_error),    64'd0);
      check_output({tag, "_s_transfer"}, 64'(bus.s_transfer), 64'd0);
      check_output({tag, "_s_write"},    64'(bus.s_write),    64'd0);
      check_output({tag, "_s_addr"},     64'(bus.s_addr),     64'd0);
      check_output({tag, "_s_wdata"},    64'(bus.s_wdata),    64'd0);
      check_output({tag, "_grant_id"},   64'(grant_id),       64'd0);
      check_output({tag, "_busy"},       64'(busy),           64'd0);
   endtask

   // APB master model: answers each start after slave_delay cycles unless muted.
   initial begin
      logic [31:0] d;
      int          stray_done;
      stray_done  = 0;
      bus.s_ready = 1'b0;
      bus.s_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.s_transfer && !slave_mute) begin
            d = (rdata_q.size() > 0) ? rdata_q.pop_front() : 32'h0;
            repeat (slave_delay) @(posedge clk);
            #1;
            bus.s_ready = 1'b1;
            bus.s_rdata = d;
            @(posedge clk);
            #1;
            bus.s_ready = 1'b0;
            bus.s_rdata = '0;
         end else if (stray_req != stray_done) begin
            stray_done++;
            @(posedge clk);
            #1;
            bus.s_ready = 1'b1;
            bus.s_rdata = 32'h1234_5678;
            @(posedge clk);
            #1;
            bus.s_ready = 1'b0;
            bus.s_rdata = '0;
         end
      end
   end

   // Monitor: compares every APB start and every requester completion.
   initial begin
      logic       prev_xfer;
      logic       prev_ready;
      logic [1:0] exp_ready;
      xfer_t      ex;
      resp_t      er;
      prev_xfer  = 1'b0;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.s_transfer) begin
            xfer_cyc = cyc;
            check_output("xfer_one_cycle", 64'(prev_xfer), 64'd0);
            check_output("xfer_busy", 64'(busy), 64'd1);
            if (xfer_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL xfer_unexpected actual=s_transfer required=none addr=0x%0h", bus.s_addr);
            end else begin
               ex = xfer_q.pop_front();
               check_output("xfer_grant_id", 64'(grant_id),    64'(ex.id));
               check_output("xfer_s_write",  64'(bus.s_write), 64'(ex.wr));
               check_output("xfer_s_addr",   64'(bus.s_addr),  64'(ex.addr));
               check_output("xfer_s_wdata",  64'(bus.s_wdata), 64'(ex.wdata));
            end
         end
         if (bus.m_ready != '0) begin
            ready_cyc = cyc;
            if (resp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL ready_unexpected actual=0x%0h required=0x0", bus.m_ready);
            end else begin
               er = resp_q.pop_front();
               exp_ready = 2'b01 << er.id;
               check_output("resp_m_ready", 64'(bus.m_ready), 64'(exp_ready));
               check_output("resp_m_rdata", 64'(bus.m_rdata), 64'(er.rdata));
               check_output("resp_m_error", 64'(bus.m_error), 64'(er.err));
            end
         end else if (prev_ready) begin
            check_output("resp_rdata_clear", 64'(bus.m_rdata), 64'd0);
            check_output("resp_error_clear", 64'(bus.m_error), 64'd0);
         end
         prev_xfer  = bus.s_transfer;
         prev_ready = (bus.m_ready != '0);
      end
   end

   // Directed test sequence.
   initial begin
      bus.m_transfer = '0;
      bus.m_write    = '0;
      bus.m_addr     = '0;
      bus.m_wdata    = '0;

      #1 reset = 1'b0;
      #2;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      reset = 1'b1;

      $display("[TB] single read");
      slave_delay = 2;
      rdata_q.push_back(32'h0000_00A5);
      xfer_q.push_back('{0, 1'b0, 32'h1000_2000, 32'h0});
      resp_q.push_back('{0, 32'h0000_00A5, 1'b0});
      apply_stimulus(0, 1'b0, 32'h1000_2000, 32'h0);
      @(negedge clk);
      #1;
      check_output("read_latency", 64'(ready_cyc - xfer_cyc), 64'd3);

      $display("[TB] latched write");
      slave_delay = 3;
      rdata_q.push_back(32'h0);
      xfer_q.push_back('{1, 1'b1, 32'h1000_3004, 32'h0000_00FF});
      resp_q.push_back('{1, 32'h0, 1'b0});
      fork
         apply_stimulus(1, 1'b1, 32'h1000_3004, 32'h0000_00FF);
         begin
            wait_xfer("latch_xfer_wait");
            @(posedge clk);
            #1;
            bus.m_wdata[32 +: 32] = 32'h0;
            bus.m_addr[32 +: 32]  = 32'h0;
            bus.m_write[1]        = 1'b0;
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               check_output("latch_s_wdata", 64'(bus.s_wdata), 64'h0000_00FF);
               check_output("latch_s_addr",  64'(bus.s_addr),  64'h1000_3004);
               check_output("latch_s_write", 64'(bus.s_write), 64'd1);
            end
         end
      join

      $display("[TB] contention");
      slave_delay = 1;
      xfer_q.push_back('{0, 1'b0, 32'h1000_0100, 32'h0});
      xfer_q.push_back('{1, 1'b0, 32'h1000_0200, 32'h0});
      xfer_q.push_back('{0, 1'b1, 32'h1000_0104, 32'h0000_0AAA});
      xfer_q.push_back('{1, 1'b1, 32'h1000_0204, 32'h0000_0BBB});
      rdata_q.push_back(32'h11);
      rdata_q.push_back(32'h22);
      rdata_q.push_back(32'h33);
      rdata_q.push_back(32'h44);
      resp_q.push_back('{0, 32'h11, 1'b0});
      resp_q.push_back('{1, 32'h22, 1'b0});
      resp_q.push_back('{0, 32'h33, 1'b0});
      resp_q.push_back('{1, 32'h44, 1'b0});
      fork
         begin
            apply_stimulus(0, 1'b0, 32'h1000_0100, 32'h0);
            apply_stimulus(0, 1'b1, 32'h1000_0104, 32'h0000_0AAA);
         end
         begin
            apply_stimulus(1, 1'b0, 32'h1000_0200, 32'h0);
            apply_stimulus(1, 1'b1, 32'h1000_0204, 32'h0000_0BBB);
         end
      join

      $display("[TB] timeout");
      slave_mute = 1'b1;
      xfer_q.push_back('{0, 1'b0, 32'h1000_6000, 32'h0});
      resp_q.push_back('{0, 32'hDEAD_BEEF, 1'b1});
      apply_stimulus(0, 1'b0, 32'h1000_6000, 32'h0);
      @(negedge clk);
      #1;
      check_output("timeout_latency", 64'(ready_cyc - xfer_cyc), 64'd9);
      slave_mute = 1'b0;
      rdata_q.push_back(32'h5555_AAAA);
      xfer_q.push_back('{0, 1'b0, 32'h1000_6004, 32'h0});
      resp_q.push_back('{0, 32'h5555_AAAA, 1'b0});
      apply_stimulus(0, 1'b0, 32'h1000_6004, 32'h0);

      $display("[TB] async reset during wait");
      slave_mute = 1'b1;
      xfer_q.push_back('{1, 1'b0, 32'h1000_4000, 32'h0});
      bus.m_write[1]        = 1'b0;
      bus.m_addr[32 +: 32]  = 32'h1000_4000;
      bus.m_wdata[32 +: 32] = 32'h0;
      bus.m_transfer[1]     = 1'b1;
      wait_xfer("rst_xfer_wait");
      @(posedge clk);
      #3;
      check_output("rst_pre_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      bus.m_transfer[1] = 1'b0;
      repeat (2) @(negedge clk);
      reset      = 1'b1;
      slave_mute = 1'b0;
      rdata_q.push_back(32'h0000_7777);
      xfer_q.push_back('{1, 1'b1, 32'h1000_5008, 32'h0000_00C3});
      resp_q.push_back('{1, 32'h0000_7777, 1'b0});
      apply_stimulus(1, 1'b1, 32'h1000_5008, 32'h0000_00C3);

      $display("[TB] stray ready in idle");
      @(posedge clk);
      #1;
      stray_req++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_output("stray_m_ready", 64'(bus.m_ready), 64'd0);
         check_output("stray_busy",    64'(busy),        64'd0);
      end

      repeat (3) @(negedge clk);
      check_output("xfer_q_empty", 64'(xfer_q.size()), 64'd0);
      check_output("resp_q_empty", 64'(resp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
